// File: rtl/bcd_pkg.sv
// Shared BCD digit type, limits and digit helpers.
package bcd_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

  typedef logic [3:0] bcd_digit_t;

  // True when the nibble is a legal decimal digit.
  function automatic logic is_bcd(input bcd_digit_t digit);
    return (digit <= BCD_MAX);
  endfunction

  // Non-decimal nibbles become 9, so the register can never hold A..F.
  function automatic bcd_digit_t bcd_clamp(input bcd_digit_t digit);
    return is_bcd(digit) ? digit : BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade of the up/down BCD counter.
// term flags the digit that would carry/borrow in the current direction.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       load,
  input  bcd_digit_t d,
  input  logic       step_in,
  input  logic       up,
  output bcd_digit_t q,
  output logic       term
);

  bcd_digit_t nxt;

  // Carry/borrow condition for the current direction.
  always_comb begin
    term = up ? (q == BCD_MAX) : (q == BCD_MIN);
  end

  // Next digit value for one step; 9 rolls to 0 going up, 0 to 9 going down.
  always_comb begin
    nxt = q;
    if (up) nxt = term ? BCD_MIN : q + 4'd1;
    else    nxt = term ? BCD_MAX : q - 4'd1;
  end

  // Digit register: reset > clear > load > step > hold.
  always_ff @(posedge clk) begin
    if (reset)        q <= BCD_MIN;
    else if (clear)   q <= BCD_MIN;
    else if (load)    q <= bcd_clamp(d);
    else if (step_in) q <= nxt;
  end

endmodule

// File: rtl/bcd_updown_counter.sv
// N-decade synchronous BCD up/down counter with load, wrap/saturate,
// sticky overflow and combinational terminal count.
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS   = 3,
  parameter bit SATURATE = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  enable,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tc,
  output logic                  overflow,
  output logic                  load_err
);

  logic [DIGITS-1:0][3:0] digs;
  logic [DIGITS-1:0][3:0] ld_digs;
  logic [DIGITS-1:0]      step_in;
  logic [DIGITS-1:0]      dig_step;
  logic [DIGITS-1:0]      term;
  logic [DIGITS-1:0]      bad;
  logic                   hold;

  assign ld_digs = load_value;
  assign count   = digs;

  // A decade steps when enabled and every lower decade is at its terminal value.
  for (genvar k = 0; k < DIGITS; k++) begin : g_chain
    if (k == 0) begin : g_first
      assign step_in[k] = enable;
    end else begin : g_rest
      assign step_in[k] = step_in[k-1] & term[k-1];
    end
    assign bad[k] = ~is_bcd(ld_digs[k]);
  end

  // Terminal count only when a plain count step would actually happen.
  assign tc   = step_in[DIGITS-1] & term[DIGITS-1] & ~load & ~clear & ~reset;
  // In saturate mode the terminal step is swallowed so every digit holds.
  assign hold = SATURATE ? tc : 1'b0;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    assign dig_step[k] = step_in[k] & ~hold;
    bcd_digit u_digit (
      .clk     (clk),
      .reset   (reset),
      .clear   (clear),
      .load    (load),
      .d       (ld_digs[k]),
      .step_in (dig_step[k]),
      .up      (up),
      .q       (digs[k]),
      .term    (term[k])
    );
  end

  // Sticky overflow set by any terminal step; load_err pulses on a bad load.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      overflow <= 1'b0;
      load_err <= 1'b0;
    end else if (load) begin
      overflow <= 1'b0;
      load_err <= |bad;
    end else begin
      load_err <= 1'b0;
      if (tc) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Scoreboard bench: a wrapping and a saturating counter share stimulus;
// an integer model predicts each edge and results are queued, then popped.
module tb_bcd_updown_counter;

  localparam int D    = 3;
  localparam int MAXV = 999;

  typedef struct {
    logic [11:0] c0, c1;
    logic        o0, o1, l0, l1;
  } exp_t;

  typedef struct {
    logic r, c, l;
    logic [11:0] lv;
    logic e, u;
  } stim_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1, clear = 1'b0, enable = 1'b0, up = 1'b1, load = 1'b0;
  logic [11:0] load_value = '0;
  logic [11:0] cnt0, cnt1;
  logic        tc0, tc1, ovf0, ovf1, lerr0, lerr1;

  int   checks = 0;
  int   errors = 0;
  bit   armed  = 1'b0;
  exp_t sb[$];
  int   m_cnt[2];
  logic m_ovf[2], m_lerr[2], exp_tc[2];

  always #5 clk = ~clk;

  bcd_updown_counter #(.DIGITS(D), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .reset(reset), .clear(clear), .enable(enable), .up(up), .load(load),
    .load_value(load_value), .count(cnt0), .tc(tc0), .overflow(ovf0), .load_err(lerr0));

  bcd_updown_counter #(.DIGITS(D), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .reset(reset), .clear(clear), .enable(enable), .up(up), .load(load),
    .load_value(load_value), .count(cnt1), .tc(tc1), .overflow(ovf1), .load_err(lerr1));

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r;
    int t;
    t = v;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int clamp_val(input logic [11:0] b);
    int v, m;
    v = 0; m = 1;
    for (int i = 0; i < D; i++) begin
      v += ((b[4*i +: 4] > 4'd9) ? 9 : int'(b[4*i +: 4])) * m;
      m *= 10;
    end
    return v;
  endfunction

  function automatic logic has_bad(input logic [11:0] b);
    logic r;
    r = 1'b0;
    for (int i = 0; i < D; i++) if (b[4*i +: 4] > 4'd9) r = 1'b1;
    return r;
  endfunction

  // Applies inputs after a falling edge, predicts tc now and state after the next edge.
  task automatic drive(input stim_t s);
    exp_t x;
    @(negedge clk);
    reset = s.r; clear = s.c; load = s.l; load_value = s.lv; enable = s.e; up = s.u;
    for (int k = 0; k < 2; k++) begin
      exp_tc[k] = s.e & ~s.l & ~s.c & ~s.r & (s.u ? (m_cnt[k] == MAXV) : (m_cnt[k] == 0));
      if (s.r || s.c) begin
        m_cnt[k] = 0; m_ovf[k] = 1'b0; m_lerr[k] = 1'b0;
      end else if (s.l) begin
        m_cnt[k] = clamp_val(s.lv); m_ovf[k] = 1'b0; m_lerr[k] = has_bad(s.lv);
      end else begin
        m_lerr[k] = 1'b0;
        if (s.e) begin
          if (exp_tc[k]) begin
            m_ovf[k] = 1'b1;
            if (k == 0) m_cnt[k] = s.u ? 0 : MAXV;
          end else begin
            m_cnt[k] = s.u ? m_cnt[k] + 1 : m_cnt[k] - 1;
          end
        end
      end
    end
    x.c0 = to_bcd(m_cnt[0]); x.o0 = m_ovf[0]; x.l0 = m_lerr[0];
    x.c1 = to_bcd(m_cnt[1]); x.o1 = m_ovf[1]; x.l1 = m_lerr[1];
    sb.push_back(x);
  endtask

  function automatic stim_t mk(input logic r, c, l, input logic [11:0] lv, input logic e, u);
    stim_t s;
    s.r = r; s.c = c; s.l = l; s.lv = lv; s.e = e; s.u = u;
    return s;
  endfunction

  // Every digit of both counters must stay decimal once reset has been seen.
  always @(negedge clk) begin
    if (armed) begin
      for (int i = 0; i < D; i++) begin
        assert (cnt0[4*i +: 4] <= 4'd9 && cnt1[4*i +: 4] <= 4'd9) else begin
          errors++;
          $display("FAIL bcd_invariant digit %0d got %h/%h required <=9", i, cnt0, cnt1);
        end
      end
    end
  end

  task automatic test_reset();
    stim_t st[$];
    exp_t  e;
    st.push_back(mk(1, 0, 0, 12'h000, 0, 1));
    st.push_back(mk(1, 0, 0, 12'h000, 1, 0));
    foreach (st[i]) begin
      drive(st[i]);
      #1; checks++;
      if ({tc0, tc1} !== {exp_tc[0], exp_tc[1]}) begin
        errors++; $display("FAIL reset_tc got %b%b required %b%b", tc0, tc1, exp_tc[0], exp_tc[1]);
      end
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({cnt0, ovf0, lerr0, cnt1, ovf1, lerr1} !== {12'h000, 2'b00, 12'h000, 2'b00}) begin
        errors++; $display("FAIL reset_state got %h %b %b / %h %b %b required 000 0 0", cnt0, ovf0, lerr0, cnt1, ovf1, lerr1);
      end
    end
    armed = 1'b1;
  endtask

  task automatic test_count_up();
    exp_t e;
    for (int i = 0; i < 125; i++) begin
      drive(mk(0, 0, 0, 12'h000, 1, 1));
      #1; checks++;
      if ({tc0, tc1} !== {exp_tc[0], exp_tc[1]}) begin
        errors++; $display("FAIL count_up_tc cyc %0d got %b%b required %b%b", i, tc0, tc1, exp_tc[0], exp_tc[1]);
      end
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({cnt0, ovf0, lerr0, cnt1, ovf1, lerr1} !== {e.c0, e.o0, e.l0, e.c1, e.o1, e.l1}) begin
        errors++; $display("FAIL count_up cyc %0d got %h %b %b / %h %b %b required %h %b %b / %h %b %b",
          i, cnt0, ovf0, lerr0, cnt1, ovf1, lerr1, e.c0, e.o0, e.l0, e.c1, e.o1, e.l1);
      end
    end
    checks++;
    if ({cnt0, tc0, ovf0} !== {12'h125, 2'b00}) begin
      errors++; $display("FAIL count_up_final got %h tc %b ovf %b required 125 0 0", cnt0, tc0, ovf0);
    end
  endtask

  // Runs a stimulus list with tc checked before each edge and state after it.
  task automatic test_sequence(input string name, input stim_t st[$]);
    exp_t e;
    foreach (st[i]) begin
      drive(st[i]);
      #1; checks++;
      if ({tc0, tc1} !== {exp_tc[0], exp_tc[1]}) begin
        errors++; $display("FAIL %s_tc step %0d got %b%b required %b%b", name, i, tc0, tc1, exp_tc[0], exp_tc[1]);
      end
      @(posedge clk); #1;
      if (sb.size() == 0) begin
        errors++; $display("FAIL %s scoreboard empty at step %0d", name, i);
      end else begin
        e = sb.pop_front();
        checks++;
        if ({cnt0, ovf0, lerr0} !== {e.c0, e.o0, e.l0}) begin
          errors++; $display("FAIL %s_wrap step %0d got %h %b %b required %h %b %b", name, i, cnt0, ovf0, lerr0, e.c0, e.o0, e.l0);
        end
        checks++;
        if ({cnt1, ovf1, lerr1} !== {e.c1, e.o1, e.l1}) begin
          errors++; $display("FAIL %s_sat step %0d got %h %b %b required %h %b %b", name, i, cnt1, ovf1, lerr1, e.c1, e.o1, e.l1);
        end
      end
    end
  endtask

  task automatic test_wrap_up();
    stim_t st[$];
    st.push_back(mk(0, 0, 1, 12'h998, 0, 1));
    st.push_back(mk(0, 0, 0, 12'h000, 1, 1));
    st.push_back(mk(0, 0, 0, 12'h000, 1, 1));
    st.push_back(mk(0, 0, 0, 12'h000, 1, 1));
    test_sequence("wrap_up", st);
    checks++;
    if ({cnt0, ovf0, cnt1, ovf1} !== {12'h001, 1'b1, 12'h999, 1'b1}) begin
      errors++; $display("FAIL wrap_up_final got %h %b / %h %b required 001 1 / 999 1", cnt0, ovf0, cnt1, ovf1);
    end
  endtask

  task automatic test_down_saturate();
    stim_t st[$];
    st.push_back(mk(0, 0, 1, 12'h002, 0, 0));
    for (int i = 0; i < 5; i++) st.push_back(mk(0, 0, 0, 12'h000, 1, 0));
    test_sequence("down_sat", st);
    checks++;
    if ({cnt1, ovf1, tc1, cnt0} !== {12'h000, 2'b11, 12'h997}) begin
      errors++; $display("FAIL down_sat_final got %h %b %b / %h required 000 1 1 / 997", cnt1, ovf1, tc1, cnt0);
    end
  endtask

  task automatic test_invalid_load();
    stim_t st[$];
    st.push_back(mk(0, 0, 1, 12'h3A7, 0, 1));
    st.push_back(mk(0, 0, 0, 12'h000, 0, 1));
    st.push_back(mk(0, 0, 1, 12'hFFF, 1, 1));
    st.push_back(mk(0, 0, 1, 12'h456, 0, 1));
    test_sequence("invalid_load", st);
  endtask

  task automatic test_priority();
    stim_t st[$];
    st.push_back(mk(0, 0, 1, 12'h500, 0, 1));
    st.push_back(mk(0, 1, 1, 12'h123, 1, 1));
    st.push_back(mk(0, 0, 1, 12'h123, 0, 1));
    st.push_back(mk(1, 0, 0, 12'h000, 1, 1));
    st.push_back(mk(0, 0, 1, 12'h000, 1, 0));
    test_sequence("priority", st);
    checks++;
    if ({cnt0, cnt1} !== {12'h000, 12'h000}) begin
      errors++; $display("FAIL priority_final got %h / %h required 000", cnt0, cnt1);
    end
  endtask

  task automatic test_dir_flip();
    stim_t st[$];
    st.push_back(mk(0, 0, 1, 12'h010, 0, 1));
    st.push_back(mk(0, 0, 0, 12'h000, 1, 0));
    st.push_back(mk(0, 0, 0, 12'h000, 1, 1));
    st.push_back(mk(0, 0, 0, 12'h000, 1, 0));
    st.push_back(mk(0, 0, 0, 12'h000, 0, 0));
    test_sequence("dir_flip", st);
    checks++;
    if (cnt0 !== 12'h009) begin
      errors++; $display("FAIL dir_flip_final got %h required 009", cnt0);
    end
  endtask

  task automatic test_random();
    stim_t st[$];
    logic [11:0] picks[5];
    picks[0] = 12'h999; picks[1] = 12'h000; picks[2] = 12'h998; picks[3] = 12'h001; picks[4] = 12'h099;
    for (int i = 0; i < 400; i++) begin
      stim_t s;
      s.r  = ($urandom % 60) == 0;
      s.c  = ($urandom % 30) == 0;
      s.l  = ($urandom % 10) == 0;
      s.lv = ($urandom % 2) ? 12'($urandom) : picks[$urandom % 5];
      s.e  = ($urandom % 5) != 0;
      s.u  = ($urandom % 8) != 0 ? (i % 64 < 32) : 1'($urandom);
      st.push_back(s);
    end
    test_sequence("random", st);
  endtask

  initial begin
    m_cnt[0] = 0; m_cnt[1] = 0;
    m_ovf[0] = 1'b0; m_ovf[1] = 1'b0; m_lerr[0] = 1'b0; m_lerr[1] = 1'b0;
    test_reset();
    test_count_up();
    test_wrap_up();
    test_down_saturate();
    test_invalid_load();
    test_priority();
    test_dir_flip();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
